fpadd_sched: RTL and testbench

//  Shares one iterative fpadd unit between NREQ requesters.
//  - Round-robin arbitration; each grant owns the adder for one full operation.
//  - Sequences the adder's start/done protocol and returns the 32-bit sum to the granted requester.
//  - Sits between requester blocks and the single fpadd instance; operands and results pass through unchanged.

---
 rtl/fpadd_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/fpadd_sched.sv | 138 +++++++++++++
 tb/tb_fpadd_sched.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpadd_pkg.sv
// Shared types and constants for the fpadd request scheduler.
package fpadd_pkg;

   localparam int          FP_W = 32;
   localparam int          ID_W = 3;
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after i_ptr, wrapping at NREQ.
module rr_arbiter
   import fpadd_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [ID_W-1:0] i_ptr,
   output logic [NREQ-1:0] o_grant,
   output logic [ID_W-1:0] o_idx,
   output logic            o_any
);

   int   w_j;
   logic w_found;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_j     = 0;
      for (int k = 0; k < NREQ; k++) begin
         w_j = int'(i_ptr) + k;
         if (w_j >= NREQ) w_j = w_j - NREQ;
         if (!w_found && i_req[w_j]) begin
            o_grant[w_j] = 1'b1;
            o_idx        = ID_W'(w_j);
            w_found      = 1'b1;
         end
      end
   end

   assign o_any = |i_req;

endmodule

// File: rtl/fpadd_sched.sv
// Shares one iterative fpadd between NREQ requesters, one full operation per grant.
// Optional watchdog on the adder's done is enabled by defining FPADD_TIMEOUT_EN.
//
// state | meaning
// IDLE  | arbitrate; on a grant latch operands and requester id
// ISSUE | pulse fa_start, clear the wait counter
// WAIT  | count; accept fa_done only once the counter reaches RESULT_DELAY
// RESP  | present result until rsp_ready, then advance the round-robin pointer
module fpadd_sched
   import fpadd_pkg::*;
#(
   parameter int NREQ           = 4,
   parameter int RESULT_DELAY   = 26,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*FP_W-1:0] req_a,
   input  logic [NREQ*FP_W-1:0] req_b,
   output logic [NREQ-1:0]      req_ready,
   output logic                 rsp_valid,
   output logic [ID_W-1:0]      rsp_id,
   output logic [FP_W-1:0]      rsp_sum,
   output logic                 rsp_err,
   input  logic                 rsp_ready,
   output logic                 fa_start,
   output logic [FP_W-1:0]      fa_a,
   output logic [FP_W-1:0]      fa_b,
   input  logic [FP_W-1:0]      fa_sum,
   input  logic                 fa_done
);

   localparam int CNT_LIM = (TIMEOUT_CYCLES > RESULT_DELAY) ? TIMEOUT_CYCLES : RESULT_DELAY;
   localparam int CNT_W   = $clog2(CNT_LIM + 1);

   state_t            r_state, w_state_n;
   logic [CNT_W-1:0]  r_cnt;
   logic [ID_W-1:0]   r_ptr, r_id, w_idx;
   logic [NREQ-1:0]   w_grant;
   logic              w_any, w_hit, w_tmo;
   logic [FP_W-1:0]   r_fa_a, r_fa_b, r_sum, w_a, w_b;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .i_req   (req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   always_comb begin
      w_a = '0;
      w_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_idx == ID_W'(i)) begin
            w_a = req_a[i*FP_W +: FP_W];
            w_b = req_b[i*FP_W +: FP_W];
         end
      end
   end

   // fa_done is stale until the adder has had RESULT_DELAY cycles to normalise
   assign w_hit = (r_cnt >= CNT_W'(RESULT_DELAY)) && fa_done;

`ifdef FPADD_TIMEOUT_EN
   logic r_err;
   assign w_tmo = (r_cnt >= CNT_W'(TIMEOUT_CYCLES));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)              r_err <= 1'b0;
      else if (r_state == WAIT)  r_err <= !w_hit && w_tmo;
   end

   assign rsp_err = r_err;
`else
   assign w_tmo   = 1'b0;
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_n;
   end

   always_comb begin
      w_state_n = r_state;
      case (r_state)
         IDLE:    if (w_any) w_state_n = ISSUE;
         ISSUE:   w_state_n = WAIT;
         WAIT:    if (w_hit || w_tmo) w_state_n = RESP;
         RESP:    if (rsp_ready) w_state_n = IDLE;
         default: w_state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt  <= '0;
         r_ptr  <= '0;
         r_id   <= '0;
         r_fa_a <= '0;
         r_fa_b <= '0;
         r_sum  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_fa_a <= w_a;
                  r_fa_b <= w_b;
                  r_id   <= w_idx;
               end
            end
            ISSUE: r_cnt <= '0;
            WAIT: begin
               if (r_cnt != CNT_W'(CNT_LIM)) r_cnt <= r_cnt + 1'b1;
               if (w_hit)      r_sum <= fa_sum;
               else if (w_tmo) r_sum <= QNAN;
            end
            RESP: begin
               if (rsp_ready)
                  r_ptr <= (r_id == ID_W'(NREQ - 1)) ? '0 : r_id + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // gated by reset_n so a held request cannot leak a grant while in reset
   assign req_ready = (r_state == IDLE && reset_n) ? w_grant : '0;
   assign fa_start  = (r_state == ISSUE);
   assign rsp_valid = (r_state == RESP);
   assign rsp_id    = r_id;
   assign rsp_sum   = r_sum;
   assign fa_a      = r_fa_a;
   assign fa_b      = r_fa_b;

endmodule

// File: tb/tb_fpadd_sched.sv
// Randomised self-checking bench for fpadd_sched with a stub adder and a cycle-level reference model.
module tb_fpadd_sched;

   localparam int NREQ = 4;
   localparam int RD   = 26;
   localparam int TO   = 64;
   localparam logic [31:0] QNAN_EXP = 32'h7FC0_0000;

   logic              clk;
   logic              reset_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*32-1:0] req_a, req_b;
   logic [NREQ-1:0]   req_ready;
   logic              rsp_valid;
   logic [2:0]        rsp_id;
   logic [31:0]       rsp_sum;
   logic              rsp_err;
   logic              rsp_ready;
   logic              fa_start;
   logic [31:0]       fa_a, fa_b, fa_sum;
   logic              fa_done;

   fpadd_sched #(.NREQ(NREQ), .RESULT_DELAY(RD), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_err(rsp_err),
      .rsp_ready(rsp_ready),
      .fa_start(fa_start), .fa_a(fa_a), .fa_b(fa_b), .fa_sum(fa_sum), .fa_done(fa_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // stub adder: known case for 1.0+2.0, otherwise a fixed scramble of the operands
   function automatic logic [31:0] stub_fn(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
      return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0001;
   endfunction

   int          stub_d = 30;
   bit          stub_hold = 0;
   bit          stub_never = 0;
   int          st_cnt = 0;
   logic [31:0] st_sum;

   always @(negedge clk) begin
      if (!reset_n) st_cnt = 0;
      else if (fa_start) begin
         st_sum = stub_fn(fa_a, fa_b);
         if (stub_hold) begin
            fa_done = 1'b1; fa_sum = st_sum; st_cnt = 0;
         end else begin
            fa_done = 1'b0; fa_sum = ~st_sum; st_cnt = stub_never ? 0 : stub_d;
         end
      end else if (st_cnt != 0) begin
         st_cnt--;
         if (st_cnt == 0) begin fa_done = 1'b1; fa_sum = st_sum; end
      end
   end

   // reference model: one operation at a time, expected response cycle from the rules
   bit              m_busy = 0, m_started = 0, m_err = 0, exp_rv;
   int              m_ptr = 0, m_id = 0, m_gcyc = 0, m_rcyc = 0, cyc = 0, ops = 0, n_rdy = 0;
   int              exp_j, jj, dd;
   logic [NREQ-1:0] exp_vec, g_seen = '0;
   logic [31:0]     m_a, m_b, m_sum, last_sum = '0;
   int              glog[$];

   always @(negedge clk) begin
      if (!reset_n) begin
         m_busy = 0; m_started = 0; m_ptr = 0; g_seen = '0;
      end else begin
         cyc++;
         g_seen = req_ready;
         if (req_ready != '0) n_rdy++;
         if (!m_busy) begin
            exp_j = -1;
            for (int k = 0; k < NREQ; k++) begin
               jj = (m_ptr + k) % NREQ;
               if (exp_j < 0 && req_valid[jj]) exp_j = jj;
            end
            exp_vec = (exp_j >= 0) ? (NREQ'(1) << exp_j) : '0;
            chk("grant", 32'(req_ready), 32'(exp_vec));
            chk("idle_outs", {30'd0, rsp_valid, fa_start}, 32'd0);
            for (int k = 0; k < NREQ; k++) if (req_ready[k]) glog.push_back(k);
            if (exp_j >= 0) begin
               m_busy = 1; m_started = 0; m_id = exp_j; m_gcyc = cyc;
               m_a = req_a[exp_j*32 +: 32];
               m_b = req_b[exp_j*32 +: 32];
            end
         end else begin
            chk("rdy_busy", 32'(req_ready), 32'd0);
            chk("fa_start", 32'(fa_start), 32'(!m_started && cyc == m_gcyc + 1));
            if (!m_started && cyc == m_gcyc + 1) begin
               m_started = 1;
               dd = stub_never ? TO + 1 : (stub_hold ? 0 : stub_d);
               m_rcyc = cyc + 1 + ((RD + 1 > dd) ? RD + 1 : dd);
               m_sum  = stub_never ? QNAN_EXP : stub_fn(m_a, m_b);
               m_err  = stub_never;
            end
            if (m_started) begin
               chk("fa_a", fa_a, m_a);
               chk("fa_b", fa_b, m_b);
            end
            exp_rv = m_started && cyc >= m_rcyc;
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            if (rsp_valid && exp_rv) begin
               chk("rsp_id", 32'(rsp_id), 32'(m_id));
               chk("rsp_sum", rsp_sum, m_sum);
               chk("rsp_err", 32'(rsp_err), 32'(m_err));
               last_sum = rsp_sum;
            end
            if (exp_rv && rsp_ready) begin
               m_ptr = (m_id + 1) % NREQ; m_busy = 0; ops++;
            end
         end
      end
   end

   bit persist = 0;

   task automatic tick();
      @(posedge clk); #1;
      if (!persist) req_valid = req_valid & ~g_seen;
   endtask

   task automatic wait_ops(input string tag, input int target, input int budget);
      int n = 0;
      while (ops < target && n < budget) begin tick(); n++; end
      chk(tag, 32'(ops >= target), 32'd1);
   endtask

   task automatic drain();
      int n = 0;
      persist = 0; req_valid = '0; rsp_ready = 1'b1;
      while (m_busy && n < 200) begin tick(); n++; end
      chk("drain", 32'(m_busy), 32'd0);
   endtask

   int base, gsz, rdy0, n;

   initial begin
      reset_n = 1'b0; req_valid = '1; req_a = '0; req_b = '0; rsp_ready = 1'b0;
      fa_done = 1'b0; fa_sum = '0;
      #12;
      chk("rst_outs", {26'd0, req_ready, rsp_valid, fa_start}, 32'd0);
      chk("rst_rsp", {28'd0, rsp_id, rsp_err}, 32'd0);
      chk("rst_sum", rsp_sum, 32'd0);
      chk("rst_fa", fa_a | fa_b, 32'd0);
      req_valid = '0; rsp_ready = 1'b1;
      @(posedge clk); #1; reset_n = 1'b1;

      // all requesters held: fresh pointer gives order 0,1,2,3
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*32 +: 32] = 32'h1000_0000 + i; req_b[i*32 +: 32] = 32'h2000_0000 + i;
      end
      base = glog.size(); persist = 1; req_valid = '1;
      wait_ops("t2_ops", ops + 4, 4 * 40);
      persist = 0; req_valid = '0;
      for (int i = 0; i < 4; i++) chk("t2_order", 32'(glog[base + i]), 32'(i));
      drain();

      // single requester, 1.0 + 2.0
      req_a[31:0] = 32'h3F80_0000; req_b[31:0] = 32'h4000_0000; req_valid = 4'b0001;
      wait_ops("t1_ops", ops + 1, 60);
      chk("t1_sum", last_sum, 32'h4040_0000);
      chk("t1_id", 32'(glog[glog.size() - 1]), 32'd0);
      drain();

      // stale done held high across start
      stub_hold = 1; fa_done = 1'b1; fa_sum = 32'hDEAD_BEEF;
      req_a[63:32] = 32'h4120_0000; req_b[63:32] = 32'h4130_0000; req_valid = 4'b0010;
      wait_ops("t3_ops", ops + 1, 60);
      stub_hold = 0;
      drain();

      // consumer stall with other requesters waiting
      rsp_ready = 1'b0; persist = 1; req_valid = 4'b0101;
      n = 0;
      while (!rsp_valid && n < 80) begin tick(); n++; end
      chk("t4_rv_seen", 32'(rsp_valid), 32'd1);
      rdy0 = n_rdy;
      repeat (10) tick();
      chk("t4_no_grant", 32'(n_rdy - rdy0), 32'd0);
      chk("t4_rv_held", 32'(rsp_valid), 32'd1);
      rsp_ready = 1'b1;
      wait_ops("t4_ops", ops + 1, 5);
      persist = 0; req_valid = '0;
      drain();

      // leave the pointer at 3, then abandon an op by reset in WAIT
      req_valid = 4'b0100;
      wait_ops("t5_pre", ops + 1, 60);
      drain();
      req_a[31:0] = 32'h1111_1111; req_b[31:0] = 32'h2222_2222; req_valid = 4'b0001;
      n = 0;
      while (!m_started && n < 10) begin tick(); n++; end
      repeat (5) tick();
      reset_n = 1'b0; req_valid = 4'b1100;
      #1;
      chk("t5_outs", {26'd0, req_ready, rsp_valid, fa_start}, 32'd0);
      chk("t5_err_id", {28'd0, rsp_id, rsp_err}, 32'd0);
      chk("t5_fa", fa_a | fa_b, 32'd0);
      chk("t5_sum", rsp_sum, 32'd0);
      repeat (3) @(posedge clk);
      #1; reset_n = 1'b1;
      gsz = glog.size();
      wait_ops("t5_ops", ops + 2, 2 * 40);
      chk("t5_first", 32'(glog[gsz]), 32'd2);
      drain();

      // randomised traffic, operands, adder latency and consumer back-pressure
      base = ops;
      n = 0;
      while (ops < base + 40 && n < 40 * 90) begin
         tick(); n++;
         req_valid = NREQ'($urandom);
         for (int i = 0; i < NREQ; i++) begin
            req_a[i*32 +: 32] = $urandom; req_b[i*32 +: 32] = $urandom;
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         stub_d    = $urandom_range(1, 40);
         stub_hold = ($urandom_range(0, 4) == 0);
      end
      chk("rand_ops", 32'(ops >= base + 40), 32'd1);
      stub_hold = 0; stub_d = 30;
      drain();

`ifdef FPADD_TIMEOUT_EN
      stub_never = 1;
      req_a[31:0] = 32'h3F80_0000; req_b[31:0] = 32'h3F80_0000; req_valid = 4'b0001;
      wait_ops("t6_ops", ops + 1, TO + 20);
      chk("t6_sum", last_sum, QNAN_EXP);
      stub_never = 0;
      drain();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
